// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared types and constants for the multi-channel linear interpolator
package interp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int DEF_LOG2L = 2;
    localparam int L         = 1 << DEF_LOG2L;

    // Interpolation factor for a given log2 ratio
    function automatic int interp_factor(input int log2l);
        return 1 << log2l;
    endfunction

endpackage

// File: rtl/interp_lane.sv
// rtl/interp_lane.sv - one channel of the interpolator: sample, slope, accumulator, output
module interp_lane
    import interp_pkg::*;
#(
    parameter int DW    = 18,
    parameter int LOG2L = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic          issue_first,
    input  logic          hold,
    input  logic [DW-1:0] xin,
    output logic [DW-1:0] yout
);

    localparam int AW = DW + LOG2L + 1;

    logic signed [DW-1:0] x_curr;
    logic signed [DW:0]   delta;
    logic signed [AW-1:0] acc;

    logic [DW:0]   delta_new;
    logic [AW-1:0] acc_load;
    logic [AW-1:0] delta_new_ext;
    logic [AW-1:0] delta_ext;
    logic [DW-1:0] seg_start;

    // Slope of the new segment and the scaled segment start, sign-extended
    assign delta_new     = {xin[DW-1], xin} - {x_curr[DW-1], x_curr};
    assign acc_load      = {{(LOG2L+1){x_curr[DW-1]}}, x_curr} <<< LOG2L;
    assign delta_new_ext = {{LOG2L{delta_new[DW]}}, delta_new};
    assign delta_ext     = {{LOG2L{delta[DW]}}, delta};
    // After a load x_curr holds the new sample, so the segment start is x_curr - delta
    assign seg_start     = x_curr - delta[DW-1:0];

    // Load a new segment on clkenin, otherwise step the accumulator on each output
    always_ff @(posedge clock) begin
        if (reset) begin
            x_curr <= '0;
            delta  <= '0;
            acc    <= '0;
            yout   <= '0;
        end else if (load) begin
            x_curr <= xin;
            delta  <= delta_new;
            if (issue_first) begin
                acc  <= acc_load + delta_new_ext;
                yout <= x_curr;
            end else begin
                acc  <= acc_load;
            end
        end else if (step) begin
            yout <= hold ? seg_start : acc[DW+LOG2L-1:LOG2L];
            acc  <= acc + delta_ext;
        end
    end

endmodule

// File: rtl/interp_lin_nch.sv
// rtl/interp_lin_nch.sv - NCH-channel linear/zero-order-hold upsampler by 2^LOG2L
module interp_lin_nch
    import interp_pkg::*;
#(
    parameter int DW    = 18,
    parameter int NCH   = 2,
    parameter int LOG2L = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clkenin,
    input  logic              clkenout,
    input  logic              mode,
    input  logic [NCH*DW-1:0] xkin,
    output logic [NCH*DW-1:0] ykout,
    output logic              yvalid,
    output logic              sync_err
);

    localparam int LF = interp_factor(LOG2L);
    localparam logic [LOG2L:0] PH_END = {1'b1, {LOG2L{1'b0}}};
    localparam logic [LOG2L:0] PH_ONE = (LOG2L+1)'(1);

    state_t         state_q;
    state_t         state_d;
    logic [LOG2L:0] phase;
    logic           mode_r;

    logic in_run;
    logic step_en;
    logic excess;
    logic first_out;

    assign in_run    = (state_q == RUN);
    assign step_en   = clkenout & ~clkenin & in_run & (phase < PH_END);
    assign excess    = clkenout & ~clkenin & in_run & (phase == PH_END);
    // A coincident clkenin that brings the block into RUN already issues output 0
    assign first_out = clkenin & clkenout & (state_q != IDLE);

    // Next-state logic: each clkenin advances towards RUN, which only reset leaves
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clkenin) state_d = PRIME;
            PRIME:   if (clkenin) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // State, phase counter, captured mode, output strobe and sticky ratio error
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            phase    <= '0;
            mode_r   <= 1'b0;
            yvalid   <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state_q <= state_d;
            yvalid  <= clkenout & (in_run | first_out);
            if (clkenin) begin
                mode_r <= mode;
                phase  <= first_out ? PH_ONE : '0;
                if (in_run && (phase < PH_END)) sync_err <= 1'b1;
            end else if (step_en) begin
                phase <= phase + PH_ONE;
            end
            if (excess) sync_err <= 1'b1;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        interp_lane #(
            .DW    (DW),
            .LOG2L (LOG2L)
        ) u_lane (
            .clock       (clock),
            .reset       (reset),
            .load        (clkenin),
            .step        (step_en),
            .issue_first (first_out),
            .hold        (mode_r),
            .xin         (xkin[c*DW +: DW]),
            .yout        (ykout[c*DW +: DW])
        );
    end

    if (LF != (1 << LOG2L)) begin : g_bad_ratio
        $error("interpolation factor mismatch");
    end

endmodule

// File: tb/tb_interp_lin_nch.sv
// tb/tb_interp_lin_nch.sv - self-checking bench for interp_lin_nch
module tb_interp_lin_nch;

    localparam int DW    = 18;
    localparam int NCH   = 2;
    localparam int LOG2L = 2;
    localparam int L     = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              clkenin = 1'b0;
    logic              clkenout = 1'b0;
    logic              mode = 1'b0;
    logic [NCH*DW-1:0] xkin = '0;
    logic [NCH*DW-1:0] ykout;
    logic              yvalid;
    logic              sync_err;

    always #5 clock = ~clock;

    interp_lin_nch #(.DW(DW), .NCH(NCH), .LOG2L(LOG2L)) dut (
        .clock    (clock),
        .reset    (reset),
        .clkenin  (clkenin),
        .clkenout (clkenout),
        .mode     (mode),
        .xkin     (xkin),
        .ykout    (ykout),
        .yvalid   (yvalid),
        .sync_err (sync_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stream position and current segment endpoints
    int m_state;
    int m_k;
    bit m_hold;
    bit m_err;
    int m_prev [NCH];
    int m_s    [NCH];
    int m_n    [NCH];
    int m_y    [NCH];

    int    n_bad;
    string bad_msg;
    int    got_y0[$];
    int    got_y1[$];

    function automatic int to_s(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int seg_value(input int c, input int k);
        if (m_hold) return m_s[c];
        return m_s[c] + floor_div(k * (m_n[c] - m_s[c]), L);
    endfunction

    task automatic model_reset();
        m_state = 0; m_k = 0; m_hold = 0; m_err = 0;
        for (int c = 0; c < NCH; c++) begin
            m_prev[c] = 0; m_s[c] = 0; m_n[c] = 0; m_y[c] = 0;
        end
    endtask

    task automatic clear_log();
        n_bad = 0;
        bad_msg = "";
        got_y0.delete();
        got_y1.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clkenin = 1'b1;
        clkenout = 1'b1;
        xkin = {DW'(1234), DW'(-77)};
        @(posedge clock); #1;
        reset = 1'b0;
        clkenin = 1'b0;
        clkenout = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input bit cin, input bit cout, input int n0, input int n1, input bit md);
        bit                ev;
        logic [NCH*DW-1:0] ey;
        int                nn [NCH];
        nn[0] = n0;
        nn[1] = n1;
        ev = 1'b0;
        if (cin) begin
            if (m_state == 2 && m_k < L) m_err = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                m_s[c] = m_prev[c];
                m_n[c] = nn[c];
                m_prev[c] = nn[c];
            end
            m_hold = md;
            m_k = 0;
            if (cout && m_state != 0) begin
                ev = 1'b1;
                for (int c = 0; c < NCH; c++) m_y[c] = seg_value(c, 0);
                m_k = 1;
            end
            if (m_state < 2) m_state++;
        end else if (cout && m_state == 2) begin
            ev = 1'b1;
            if (m_k < L) begin
                for (int c = 0; c < NCH; c++) m_y[c] = seg_value(c, m_k);
                m_k++;
            end else begin
                m_err = 1'b1;
            end
        end
        for (int c = 0; c < NCH; c++) ey[c*DW +: DW] = DW'(m_y[c]);

        clkenin = cin;
        clkenout = cout;
        mode = md;
        xkin = {DW'(n1), DW'(n0)};
        @(posedge clock); #1;
        clkenin = 1'b0;
        clkenout = 1'b0;
        mode = 1'b0;

        if (yvalid !== ev || sync_err !== m_err || ykout !== ey) begin
            if (n_bad == 0)
                bad_msg = $sformatf("t=%0t yvalid %b want %b sync_err %b want %b ykout %h want %h",
                                    $time, yvalid, ev, sync_err, m_err, ykout, ey);
            n_bad++;
        end
        if (yvalid === 1'b1) begin
            got_y0.push_back(to_s(ykout[DW-1:0]));
            got_y1.push_back(to_s(ykout[2*DW-1:DW]));
        end
    endtask

    // One input period: clkenin (optionally on a clkenout) then nout output enables
    task automatic period(input int n0, input int n1, input bit md, input int nout, input bit coin);
        if (coin) begin
            cycle(1'b1, 1'b1, n0, n1, md);
            cycle(1'b0, 1'b0, n0, n1, 1'b0);
            for (int i = 1; i < nout; i++) begin
                cycle(1'b0, 1'b1, n0, n1, 1'b0);
                cycle(1'b0, 1'b0, n0, n1, 1'b0);
            end
        end else begin
            cycle(1'b1, 1'b0, n0, n1, md);
            cycle(1'b0, 1'b0, n0, n1, 1'b0);
            for (int i = 0; i < nout; i++) begin
                cycle(1'b0, 1'b1, n0, n1, 1'b0);
                cycle(1'b0, 1'b0, n0, n1, 1'b0);
            end
        end
    endtask

    task automatic test_reset();
        clear_log();
        do_reset();
        checks++; if (ykout !== '0) begin errors++; $display("FAIL reset_ykout: got %h want 0", ykout); end
        checks++; if (yvalid !== 1'b0) begin errors++; $display("FAIL reset_yvalid: got %b want 0", yvalid); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
        cycle(1'b0, 1'b1, 5, 5, 1'b0);
        checks++; if (yvalid !== 1'b0) begin errors++; $display("FAIL idle_clkenout_yvalid: got %b want 0", yvalid); end
    endtask

    task automatic test_linear_ramp();
        int e[8];
        e = '{0, 100, 200, 300, 400, 400, 400, 400};
        do_reset();
        clear_log();
        period(0, 0, 1'b0, L, 1'b1);
        checks++; if (got_y0.size() !== 0) begin errors++; $display("FAIL ramp_prime_outputs: got %0d want 0", got_y0.size()); end
        period(400, 0, 1'b0, L, 1'b1);
        period(400, 0, 1'b0, L, 1'b1);
        checks++; if (got_y0.size() !== 8) begin errors++; $display("FAIL ramp_count: got %0d want 8", got_y0.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= got_y0.size() || got_y0[i] !== e[i]) begin
                errors++;
                $display("FAIL ramp_y%0d: got %0d want %0d", i, (i < got_y0.size()) ? got_y0[i] : -999999, e[i]);
            end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL ramp_model: %0d cycles off, first %s", n_bad, bad_msg); end
    endtask

    task automatic test_negative_slope();
        int e0[4];
        e0 = '{400, 200, 0, -200};
        do_reset();
        clear_log();
        period(0, 0, 1'b0, L, 1'b1);
        period(400, 7, 1'b0, L, 1'b1);
        clear_log();
        period(-400, 7, 1'b0, L, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_y0.size() || got_y0[i] !== e0[i] || got_y1[i] !== 7) begin
                errors++;
                $display("FAIL neg_y%0d: got %0d/%0d want %0d/7", i,
                         (i < got_y0.size()) ? got_y0[i] : -999999,
                         (i < got_y1.size()) ? got_y1[i] : -999999, e0[i]);
            end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL neg_model: %0d cycles off, first %s", n_bad, bad_msg); end
    endtask

    task automatic test_truncation();
        int e[8];
        e = '{0, 0, 1, 2, 3, 2, 1, 0};
        do_reset();
        clear_log();
        period(0, 0, 1'b0, L, 1'b1);
        period(3, -3, 1'b0, L, 1'b1);
        period(0, 0, 1'b0, L, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= got_y0.size() || got_y0[i] !== e[i]) begin
                errors++;
                $display("FAIL trunc_y%0d: got %0d want %0d", i, (i < got_y0.size()) ? got_y0[i] : -999999, e[i]);
            end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL trunc_model: %0d cycles off, first %s", n_bad, bad_msg); end
    endtask

    task automatic test_hold();
        int e[12];
        e = '{0, 0, 0, 0, 400, 400, 400, 400, 400, 300, 200, 100};
        do_reset();
        clear_log();
        period(0, 0, 1'b0, L, 1'b1);
        period(400, 400, 1'b1, L, 1'b1);
        period(400, 400, 1'b0, L, 1'b1);
        period(0, 0, 1'b0, L, 1'b1);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i >= got_y0.size() || got_y0[i] !== e[i]) begin
                errors++;
                $display("FAIL hold_y%0d: got %0d want %0d", i, (i < got_y0.size()) ? got_y0[i] : -999999, e[i]);
            end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL hold_model: %0d cycles off, first %s", n_bad, bad_msg); end
    endtask

    task automatic test_ratio_faults();
        int e[11];
        int ex[5];
        e  = '{0, 100, 200, 300, 400, 500, 600, 800, 600, 400, 200};
        ex = '{0, 100, 200, 300, 300};
        do_reset();
        clear_log();
        period(0, 0, 1'b0, L, 1'b1);
        period(400, 0, 1'b0, L, 1'b1);
        period(800, 0, 1'b0, 3, 1'b1);
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL early_before: got %b want 0", sync_err); end
        period(0, 0, 1'b0, L, 1'b1);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL early_sync_err: got %b want 1", sync_err); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (i >= got_y0.size() || got_y0[i] !== e[i]) begin
                errors++;
                $display("FAIL early_y%0d: got %0d want %0d", i, (i < got_y0.size()) ? got_y0[i] : -999999, e[i]);
            end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL early_model: %0d cycles off, first %s", n_bad, bad_msg); end

        do_reset();
        clear_log();
        period(0, 0, 1'b0, L, 1'b1);
        period(400, 0, 1'b0, 5, 1'b1);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL excess_sync_err: got %b want 1", sync_err); end
        checks++; if (got_y0.size() !== 5) begin errors++; $display("FAIL excess_count: got %0d want 5", got_y0.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got_y0.size() || got_y0[i] !== ex[i]) begin
                errors++;
                $display("FAIL excess_y%0d: got %0d want %0d", i, (i < got_y0.size()) ? got_y0[i] : -999999, ex[i]);
            end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL excess_model: %0d cycles off, first %s", n_bad, bad_msg); end
    endtask

    task automatic test_reset_mid();
        int e[4];
        e = '{50, 60, 70, 80};
        do_reset();
        clear_log();
        period(0, 0, 1'b0, L, 1'b1);
        period(400, 400, 1'b0, 5, 1'b1);
        cycle(1'b1, 1'b1, 800, 800, 1'b0);
        cycle(1'b0, 1'b1, 800, 800, 1'b0);
        do_reset();
        checks++; if (ykout !== '0) begin errors++; $display("FAIL midreset_ykout: got %h want 0", ykout); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL midreset_sync_err: got %b want 0", sync_err); end
        clear_log();
        period(50, 50, 1'b0, L, 1'b1);
        checks++; if (got_y0.size() !== 0) begin errors++; $display("FAIL midreset_first_in: got %0d outputs want 0", got_y0.size()); end
        period(90, 90, 1'b0, L, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_y0.size() || got_y0[i] !== e[i]) begin
                errors++;
                $display("FAIL midreset_y%0d: got %0d want %0d", i, (i < got_y0.size()) ? got_y0[i] : -999999, e[i]);
            end
        end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL midreset_model: %0d cycles off, first %s", n_bad, bad_msg); end
    endtask

    task automatic test_random();
        int a;
        int b;
        do_reset();
        clear_log();
        period(int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072,
               1'b0, L, 1'($urandom_range(0, 1)));
        for (int p = 0; p < 30; p++) begin
            a = int'($urandom_range(0, 262143)) - 131072;
            b = int'($urandom_range(0, 262143)) - 131072;
            period(a, b, 1'($urandom_range(0, 1)), L, 1'($urandom_range(0, 1)));
        end
        checks++; if (got_y0.size() !== 120) begin errors++; $display("FAIL random_count: got %0d want 120", got_y0.size()); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL random_sync_err: got %b want 0", sync_err); end
        checks++; if (n_bad !== 0) begin errors++; $display("FAIL random_model: %0d cycles off, first %s", n_bad, bad_msg); end
    endtask

    initial begin
        model_reset();
        clear_log();
        test_reset();
        test_linear_ramp();
        test_negative_slope();
        test_truncation();
        test_hold();
        test_ratio_faults();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interp_lin_nch.md
# interp_lin_nch

Parametrised multi-channel linear interpolator that upsamples NCH parallel sample streams by L = 2^LOG2L between two clock-enable domains on a single clock. It supersedes the fixed 4x two-instance arrangement between the 48 kHz stereo-matrix stage and the 192 kHz pilot/FM stage of the modulator. It adds a zero-order-hold mode, an output-valid strobe and a sticky enable-ratio error flag.

## Interface
- DW, 18, sample width (signed two's complement) per channel
- NCH, 2, channel count (e.g. L+R, L-R)
- LOG2L, 2, log2 of interpolation factor L
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clkenin  in  1  input-rate sample enable (48 kHz)
- clkenout  in  1  output-rate enable (192 kHz)
- mode  in  1  0 = linear, 1 = zero-order hold; sampled at each clkenin
- xkin  in  NCH*DW  input samples, channel c at bits [c*DW +: DW]
- ykout  out  NCH*DW  interpolated samples, same packing
- yvalid  out  1  one-cycle pulse when ykout updates
- sync_err  out  1  sticky: enable ratio differs from L

## Operation
- States: IDLE (after reset) -> PRIME (first clkenin) -> RUN (second clkenin). IDLE/PRIME: ykout = 0, yvalid = 0. RUN is left only by reset.
- Per channel: x_curr (DW), delta (DW+1 signed), acc (DW+LOG2L+1 signed). Shared: phase counter 0..L, mode_r.
- On clkenin, every state: delta <= xkin - x_curr; acc <= x_curr <<< LOG2L; x_curr <= xkin; mode_r <= mode; phase <= 0.
- On clkenout in RUN, without clkenin: if phase < L, ykout <= acc >>> LOG2L (mode_r = 0) or segment start (mode_r = 1); acc <= acc + delta; phase++.
- Outputs therefore step through the segment start s and new sample n as y_k = s + floor(k*(n - s)/L) for k = 0..L-1. The floor comes from arithmetic right shift.
- No saturation is needed: y_k always lies between s and n.
- Coincident clkenin and clkenout in RUN: the load rules apply, and the same edge issues output k = 0 of the new segment.
  - ykout <= old x_curr
  - acc <= (old x_curr <<< LOG2L) + delta_new
  - phase <= 1
- Early clkenin in RUN (phase < L at arrival): set sync_err, restart the segment normally.
- Excess clkenout (phase == L): ykout holds its value, yvalid still pulses, sync_err is set.
- sync_err is checked only once in RUN. The PRIME->RUN clkenin is never flagged.
- Reset (any time, including mid-segment): ykout = 0, yvalid = 0, sync_err = 0, state IDLE, all internal registers = 0.

## Timing
- ykout and yvalid update on the clock edge that samples clkenout. The new value is visible the cycle after clkenout is high, with yvalid high that same cycle.
- End-to-end latency: one input period, because segment n-1 -> n plays out after sample n arrives.
- Nominal stream: exactly L clkenout per clkenin period; clkenin may or may not coincide with a clkenout.
- yvalid is never asserted on two consecutive cycles unless clkenout is.

## Structure
- Package interp_pkg: state enum (IDLE, PRIME, RUN) and localparam L = 1 << LOG2L.
- Sub-module interp_lane: one channel's x_curr, delta, acc and output register. It is instantiated NCH times by generate.
- Top level holds the FSM, phase counter, mode_r and sync_err.

## Test plan
Unless noted, L = 4, clkenin coincides with every 4th clkenout, and the bench primes the block with a first clkenin of 0 so the segment start is 0.
- Linear ramp: samples 0 then 400 -> outputs 0, 100, 200, 300, then 400 on the next segment; yvalid pulses once per output.
- Negative slope with a second channel independent: ch0 400 -> -400 gives 400, 200, 0, -200; ch1 held at 7 gives 7, 7, 7, 7.
- Truncation: 0 -> 3 gives 0, 0, 1, 2. Then 3 -> 0 gives 3, 2, 1, 0 (floor of -3/4 is -1, so 3 - 1 = 2).
- Hold mode: mode = 1 with 0 -> 400 gives 0, 0, 0, 0.
- Ratio faults:
  - clkenin after only 3 clkenout -> sync_err = 1, new segment starts correctly.
  - 5th clkenout with no clkenin -> ykout unchanged, yvalid = 1, sync_err = 1.
- Reset: reset asserted mid-segment -> next cycle ykout = 0, sync_err = 0. The first clkenin after reset produces no yvalid; output resumes after the second clkenin.
